// File: rtl/fixedpoint_requantizer.sv
// fixedpoint_requantizer: shift, round-half-even and saturate a wide signed word
// into the narrow datapath format, as a 2-stage valid/ready pipeline.
module fixedpoint_requantizer #(
    parameter int WIDTH_INPUT  = 32,
    parameter int WIDTH_OUTPUT = 16,
    parameter int FRAC_INPUT   = 18,
    parameter int FRAC_OUTPUT  = 9,
    parameter int WIDTH_CNT    = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [WIDTH_INPUT-1:0]  data_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    output logic [WIDTH_OUTPUT-1:0] data_o,
    output logic                    sat_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    input  logic                    clr_i,
    output logic [WIDTH_CNT-1:0]    sat_cnt_o
);
    localparam int SHIFT = FRAC_INPUT - FRAC_OUTPUT;
    localparam int WR    = WIDTH_INPUT - SHIFT + 1;
    logic [WR-1:0] r, s1_r;
    logic up, s1_valid, s2_free, pos_ovf, neg_ovf;
    // data_i[SHIFT] is the LSB of the truncated value, which breaks exact ties toward even
    assign up      = data_i[SHIFT-1] & ((|data_i[SHIFT-2:0]) | data_i[SHIFT]);
    assign r       = {data_i[WIDTH_INPUT-1], data_i[WIDTH_INPUT-1:SHIFT]} + WR'(up);
    assign s2_free = !valid_o | ready_i;
    assign ready_o = !s1_valid | s2_free;
    assign pos_ovf = !s1_r[WR-1] & (|s1_r[WR-2:WIDTH_OUTPUT-1]);
    assign neg_ovf = s1_r[WR-1] & ~(&s1_r[WR-2:WIDTH_OUTPUT-1]);
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid  <= 1'b0;
            s1_r      <= '0;
            valid_o   <= 1'b0;
            data_o    <= '0;
            sat_o     <= 1'b0;
            sat_cnt_o <= '0;
        end else begin
            if (ready_o) s1_valid <= valid_i;
            if (valid_i && ready_o) s1_r <= r;
            if (s2_free) valid_o <= s1_valid;
            if (s2_free && s1_valid) begin
                data_o <= pos_ovf ? {1'b0, {(WIDTH_OUTPUT-1){1'b1}}} :
                          neg_ovf ? {1'b1, {(WIDTH_OUTPUT-1){1'b0}}} : s1_r[WIDTH_OUTPUT-1:0];
                sat_o  <= pos_ovf | neg_ovf;
            end
            if (clr_i) sat_cnt_o <= '0;
            else if (valid_o && ready_i && sat_o && !(&sat_cnt_o)) sat_cnt_o <= sat_cnt_o + WIDTH_CNT'(1);
        end
    end
endmodule

// File: doc/fixedpoint_requantizer.md
Name: fixedpoint_requantizer

Overview:
- Narrowing stage that takes wide signed fixed-point results (products/accumulations, e.g. Q13.18 in 32 bits) and returns them to the 16-bit datapath format (S | INTEGER[14:9] | FRACTION[8:0]).
- Performs arithmetic right shift, round-to-nearest-even and saturation in a 2-stage valid/ready pipeline.
- Sits at the output of the multiply-accumulate path, feeding results back into narrow-format consumers such as the fixed-point adder inputs.

Parameters:
- WIDTH_INPUT, 32, width of the signed input word.
- WIDTH_OUTPUT, 16, width of the signed output word.
- FRAC_INPUT, 18, fraction bits of the input.
- FRAC_OUTPUT, 9, fraction bits of the output.
- Derived: SHIFT = FRAC_INPUT - FRAC_OUTPUT. SHIFT >= 2 is required, and SHIFT + WIDTH_OUTPUT <= WIDTH_INPUT.
- WIDTH_CNT, 16, width of the saturation event counter.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  synchronous active-high reset.
- data_i  input  WIDTH_INPUT  signed two's-complement input word.
- valid_i  input  1  data_i valid.
- ready_o  output  1  block can accept data_i this cycle.
- data_o  output  WIDTH_OUTPUT  requantized signed result.
- sat_o  output  1  data_o was clipped; qualified by valid_o.
- valid_o  output  1  data_o/sat_o valid.
- ready_i  input  1  downstream accepts data_o.
- clr_i  input  1  synchronous clear of sat_cnt_o.
- sat_cnt_o  output  WIDTH_CNT  count of saturated outputs accepted downstream.

Behaviour:
- Clock and reset: single clock clk_i; rst_i is synchronous, active-high.
- Reset values: valid_o=0, data_o=0, sat_o=0, sat_cnt_o=0, internal stage-1 valid=0. ready_o=1 in the first cycle after reset.
- Transfers: an input transfer occurs when valid_i & ready_o; an output transfer occurs when valid_o & ready_i.
- Stage 1 (registered on input transfer):
  - t = data_i >>> SHIFT, arithmetic, floor toward minus infinity.
  - g = data_i[SHIFT-1]; s = |data_i[SHIFT-2:0]; up = g & (s | t[0]).
  - r = t + up, computed at WIDTH_INPUT-SHIFT+1 bits so it cannot wrap.
  - The stage-1 register stores r.
- Stage 2 (registered when stage-1 is valid and stage-2 is free or draining):
  - If r > 2^(WIDTH_OUTPUT-1)-1: data_o = 0x7FFF-equivalent, sat_o=1.
  - If r < -2^(WIDTH_OUTPUT-1): data_o = 0x8000-equivalent, sat_o=1.
  - Otherwise data_o = r[WIDTH_OUTPUT-1:0], sat_o=0.
- Latency and throughput: 2 cycles from input transfer to valid_o with ready_i held high; 1 result per cycle sustained.
- Flow control:
  - s2_free = !valid_o | ready_i; ready_o = !s1_valid | s2_free.
  - ready_o is combinational from ready_i; no skid buffer.
  - While valid_o & !ready_i, data_o, sat_o and valid_o hold stable. Stage 1 holds its word and ready_o=0 if stage 1 is occupied.
  - No data loss or duplication under any valid_i/ready_i pattern.
  - Bubbles: valid_o drops when stage 1 is empty and the output is accepted.
- Counter:
  - sat_cnt_o increments by 1 on each output transfer with sat_o=1.
  - Saturates at all-ones; no wrap.
  - clr_i has priority: a cycle with clr_i=1 sets sat_cnt_o=0 and drops a concurrent increment.
- Reset mid-operation: rst_i discards both pipeline stages in the same edge and clears the counter. No output transfer is reported for the discarded words.
- Exact ties round to the even result; negative values round symmetrically under the same rule (-1.5 LSB -> -2).

Test Plan:
- Reset, then ready_i=1 and data_i=0x0004_0000 (1.0) with valid_i pulsed -> 2 cycles later valid_o=1, data_o=0x0200, sat_o=0; sat_cnt_o=0.
- Rounding stream 0x0000_0100, 0x0000_0300, 0xFFFF_FD00, 0x0000_0101 back-to-back -> data_o 0x0000, 0x0002, 0xFFFE, 0x0001 on consecutive cycles, all sat_o=0.
- Boundary: 0x00FF_FE00 -> 0x7FFF, sat_o=0. 0x00FF_FF00 (rounds to 0x8000) -> 0x7FFF, sat_o=1. 0x7FFF_FFFF -> 0x7FFF, sat_o=1. 0x8000_0000 -> 0x8000, sat_o=1. Finally sat_cnt_o=3.
- Backpressure: issue 4 words and hold ready_i=0 for 5 cycles -> ready_o falls after 2 accepted, data_o stable throughout. Release ready_i -> 4 outputs in order, none lost or duplicated; random valid_i/ready_i over 1000 words matches the scoreboard.
- Counter: with sat_cnt_o=2, assert clr_i in the same cycle as a saturated output transfer -> sat_cnt_o=0. Next saturated transfer -> 1. With WIDTH_CNT=2, 5 saturations -> holds at 3.
- Reset mid-stream: both stages full, valid_o=1, rst_i for 1 cycle -> next cycle valid_o=0, data_o=0, sat_cnt_o=0, ready_o=1. The next input emerges normally after 2 cycles.
